// File: rtl/program_sequencer.sv
// ---------------------------------------------------------------------------
// program_sequencer
//
// Purpose:
//   Tiny instruction sequencer that walks a combinational program ROM and
//   issues register-file writes (ADDI) and output-port requests (OUT).
//   Each instruction takes one FETCH cycle and one EXEC cycle; an OUT that
//   is not accepted immediately parks in OUT_WAIT until the port takes it.
//   Unknown opcodes raise a sticky illegal flag and halt on the offending
//   word.
//
// Parameters:
//   ADDR_W    program ROM address width (2**ADDR_W instruction words)
//   WRAP      0: halt after the last word, 1: continue at address 0
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin execution at address 0 from IDLE or HALT
//   stop       return to IDLE once the current instruction retires
//   rom_addr   ROM address, always the program counter
//   rom_data   ROM word for rom_addr, same cycle
//   rf_we      register-file write strobe (one cycle per ADDI)
//   rf_waddr   destination register, ir[11:8]
//   rf_imm     immediate, ir[7:0]
//   rf_raddr   source register for OUT, ir[3:0]
//   out_valid  OUT request to the output port
//   out_ready  output port accepts the request
//   busy       high in FETCH, EXEC and OUT_WAIT
//   done       high in HALT
//   illegal    sticky illegal-opcode flag, cleared by start from HALT
//   retired    retired-instruction count, wraps 255 -> 0
//
// Instruction word: [15:12] opcode (0000 NOP, 0001 ADDI, 1111 OUT)
// ---------------------------------------------------------------------------
module program_sequencer #(
   parameter int ADDR_W = 3,
   parameter bit WRAP   = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              rf_we,
   output logic [3:0]        rf_waddr,
   output logic [7:0]        rf_imm,
   output logic [3:0]        rf_raddr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              illegal,
   output logic [7:0]        retired
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_OUT_WAIT,
      S_HALT
   } state_t;

   localparam logic [3:0]        OP_NOP  = 4'b0000;
   localparam logic [3:0]        OP_ADDI = 4'b0001;
   localparam logic [3:0]        OP_OUT  = 4'b1111;
   localparam logic [ADDR_W-1:0] PC_MAX  = '1;

   state_t              state_q;
   logic [ADDR_W-1:0]   pc_q;
   logic [15:0]         ir_q;
   logic                illegal_q;
   logic                rf_we_q;
   logic                out_valid_q;
   logic                busy_q;
   logic                done_q;
   logic [7:0]          retired_q;

   logic [3:0]          ir_op;
   logic [3:0]          fetch_op;
   logic                legal_op;
   logic                retire_d;
   logic                pc_last;
   logic [ADDR_W-1:0]   pc_d;

   // Decode of the latched instruction and of the word being fetched, plus
   // the retire condition. The strobes are registered, so the FETCH cycle
   // already looks at rom_data to decide what EXEC will drive.
   always_comb begin
      ir_op    = ir_q[15:12];
      fetch_op = rom_data[15:12];
      legal_op = (ir_op == OP_NOP) || (ir_op == OP_ADDI) || (ir_op == OP_OUT);
      retire_d = 1'b0;
      if (state_q == S_EXEC) begin
         retire_d = legal_op && ((ir_op != OP_OUT) || out_ready);
      end else if (state_q == S_OUT_WAIT) begin
         retire_d = out_ready;
      end
      pc_last = (pc_q == PC_MAX);
      pc_d    = pc_q + 1'b1;
   end

   // Main sequencer: state, program counter, instruction register, flags and
   // all registered outputs live here so every output changes only on a
   // clock edge (or immediately on reset). An OUT stall keeps out_valid and
   // ir untouched, which keeps rf_raddr stable for the whole wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         ir_q        <= '0;
         illegal_q   <= 1'b0;
         rf_we_q     <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         retired_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  pc_q    <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_FETCH;
               end
            end

            S_FETCH: begin
               ir_q        <= rom_data;
               rf_we_q     <= (fetch_op == OP_ADDI);
               out_valid_q <= (fetch_op == OP_OUT);
               state_q     <= S_EXEC;
            end

            S_EXEC, S_OUT_WAIT: begin
               if ((state_q == S_EXEC) && !legal_op) begin
                  // Park on the offending word so software can see where.
                  illegal_q   <= 1'b1;
                  rf_we_q     <= 1'b0;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= S_HALT;
               end else if (retire_d) begin
                  retired_q   <= retired_q + 8'd1;
                  rf_we_q     <= 1'b0;
                  out_valid_q <= 1'b0;
                  if (stop) begin
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else if (pc_last && !WRAP) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_HALT;
                  end else begin
                     // At the last word this wraps to 0 by width.
                     pc_q    <= pc_d;
                     state_q <= S_FETCH;
                  end
               end else begin
                  // Only an OUT not yet accepted gets here.
                  rf_we_q <= 1'b0;
                  state_q <= S_OUT_WAIT;
               end
            end

            S_HALT: begin
               if (start) begin
                  illegal_q <= 1'b0;
                  pc_q      <= '0;
                  done_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= S_FETCH;
               end
            end

            default: begin
               rf_we_q     <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign rom_addr  = pc_q;
   assign rf_we     = rf_we_q;
   assign rf_waddr  = ir_q[11:8];
   assign rf_imm    = ir_q[7:0];
   assign rf_raddr  = ir_q[3:0];
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign illegal   = illegal_q;
   assign retired   = retired_q;

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_W, default 3, SHALL set the program ROM address width (2^ADDR_W instruction words).
REQ-002 Parameter WRAP, default 0, SHALL select end-of-program behaviour: 0 = halt after the last word, 1 = continue at address 0.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  begin execution at address 0 from IDLE or HALT.
REQ-006 stop  input  1  return to IDLE after the current instruction retires.
REQ-007 rom_addr  output  ADDR_W  address to the combinational program ROM.
REQ-008 rom_data  input  16  instruction word returned by the ROM in the same cycle.
REQ-009 rf_we  output  1  register-file write strobe, one cycle per ADDI.
REQ-010 rf_waddr  output  4  destination select, equal to ir[11:8].
REQ-011 rf_imm  output  8  immediate operand, equal to ir[7:0].
REQ-012 rf_raddr  output  4  source select for OUT, equal to ir[3:0].
REQ-013 out_valid  output  1  OUT request to the output port.
REQ-014 out_ready  input  1  output port accepts the OUT request.
REQ-015 busy  output  1  high in FETCH, EXEC and OUT_WAIT.
REQ-016 done  output  1  high in HALT.
REQ-017 illegal  output  1  sticky illegal-opcode flag.
REQ-018 retired  output  8  count of retired instructions, wraps 255->0.

Function
REQ-019 The FSM SHALL have exactly these states: IDLE, FETCH, EXEC, OUT_WAIT, HALT.
REQ-020 rom_addr SHALL equal the internal program counter pc at all times.
REQ-021 IDLE: start=1 SHALL set pc=0 and enter FETCH on the next edge; stop SHALL be ignored in IDLE.
REQ-022 FETCH: the FSM SHALL latch ir<=rom_data and enter EXEC after exactly one cycle.
REQ-023 Decode SHALL use opcode ir[15:12]: 0000 NOP, 0001 ADDI, 1111 OUT; every other opcode is illegal.
REQ-024 EXEC with ADDI: rf_we=1 for that one cycle only, with rf_waddr and rf_imm valid in the same cycle; the instruction retires.
REQ-025 EXEC with NOP: no strobes; the instruction retires.
REQ-026 EXEC with OUT: out_valid=1 with rf_raddr valid; if out_ready=1 in that cycle the instruction retires, otherwise the FSM enters OUT_WAIT.
REQ-027 OUT_WAIT: out_valid and rf_raddr SHALL be held stable until out_ready=1; the instruction then retires in that cycle.
REQ-028 Illegal opcode in EXEC: illegal<=1, no strobes, no retire, next state HALT; pc SHALL hold the address of the offending word.
REQ-029 On retire, retired SHALL increment by 1.
REQ-030 Next state after retire when stop=1: IDLE, with pc unchanged.
REQ-031 Next state after retire when stop=0 and pc<max: FETCH with pc+1.
REQ-032 Next state after retire when stop=0 and pc=max: FETCH with pc=0 if WRAP=1, otherwise HALT.
REQ-033 Minimum latency SHALL be 2 cycles per instruction (FETCH+EXEC), plus one cycle per OUT_WAIT cycle.
REQ-034 HALT: done=1; start=1 SHALL clear illegal, set pc=0 and enter FETCH.
REQ-035 start SHALL be ignored while busy=1.
REQ-036 rf_we and out_valid SHALL be 0 in every state other than those stated above.
REQ-037 rf_waddr, rf_imm and rf_raddr SHALL be driven from ir in all states.

Reset
REQ-038 rst_n=0 SHALL immediately force: state IDLE, pc=0, ir=0, illegal=0, retired=0, rf_we=0, out_valid=0, busy=0, done=0.
REQ-039 Reset asserted mid-instruction, including in OUT_WAIT, SHALL abandon the instruction without completing the handshake or retiring it.
REQ-040 After rst_n deasserts, the FSM SHALL remain in IDLE until start=1.

Verification
REQ-041 Program {ADDI 0x2,0x33; ADDI 0x4,0xEE; 6x OUT}, WRAP=0, out_ready=1 -> rf_we pulses with (2,0x33) then (4,0xEE); 6 out_valid pulses; done=1 after 16 cycles; retired=8.
REQ-042 Same program with out_ready held low 3 cycles at the first OUT -> out_valid and rf_raddr=1 stable for 4 cycles; total 19 cycles.
REQ-043 Word 3 = 0x5000 -> illegal=1, done=1, rom_addr=3, retired=3; a following start -> illegal=0, execution resumes at address 0.
REQ-044 WRAP=1, 8 NOPs, run 600 cycles -> pc cycles 0..7 repeatedly; retired wraps past 255; done is never asserted.
REQ-045 stop pulsed during the EXEC of word 2 -> IDLE after retire with retired=3 and pc=2; start pulsed while busy=1 -> no effect.
REQ-046 rst_n pulsed low during OUT_WAIT -> out_valid=0 asynchronously; all outputs take reset values; no retire is counted.
